// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller for the 8-bit restoring shift/subtract
// divider datapath. Walks LOAD, then ITER SHIFT/EVAL pairs, then DONE.
// Optional feature macro: DIVCTRL_DBZ_EN (divide-by-zero short-circuit
// straight from IDLE to DONE with err=1, no datapath strobes).
module div_ctrl #(
  parameter int unsigned ITER = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       signbit,
  input  logic [3:0] count,
  input  logic       bzero,
  output logic       loadQ,
  output logic       loadM,
  output logic       initA0,
  output logic       init_counter,
  output logic       shift,
  output logic       PA,
  output logic       loadA,
  output logic       PQ,
  output logic       dec_counter,
  output logic       ready,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_EVAL,
    S_DONE
  } state_t;

  // Value the datapath counter is initialised to; a count above it can only
  // mean the datapath is out of step, so EVAL treats it as the last pass.
  localparam logic [3:0] CNT_INIT = 4'(ITER - 1);

  state_t state_q, state_d;
  logic   ready_q, ready_d;
  logic   load_q,  load_d;
  logic   shift_q, shift_d;
  logic   eval_q,  eval_d;
  logic   done_q,  done_d;
  logic   err_q,   err_d;

`ifndef DIVCTRL_DBZ_EN
  logic unused_bzero;
  assign unused_bzero = bzero;
`endif

  // Next-state selection plus the decode of the state about to be entered,
  // so every state-only output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
`ifdef DIVCTRL_DBZ_EN
          if (bzero) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = S_EVAL;
      S_EVAL: begin
        if ((count == '0) || (count > CNT_INIT)) state_d = S_DONE;
        else                                     state_d = S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    load_d  = (state_d == S_LOAD);
    shift_d = (state_d == S_SHIFT);
    eval_d  = (state_d == S_EVAL);
    done_d  = (state_d == S_DONE);
  end

  // State and registered output flags; reset lands in IDLE with only ready set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      eval_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      eval_q  <= eval_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready        = ready_q;
  assign loadQ        = load_q;
  assign loadM        = load_q;
  assign initA0       = load_q;
  assign init_counter = load_q;
  assign shift        = shift_q;
  // signbit only becomes meaningful once SHIFT has written the datapath, so
  // the keep/restore choice is gated by the registered EVAL flag.
  assign PA           = eval_q & ~signbit;
  assign loadA        = eval_q &  signbit;
  assign PQ           = eval_q;
  assign dec_counter  = eval_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the team's 8-bit restoring shift/subtract divider datapath. It accepts a start request, drives the datapath's load, shift, write-back and counter strobes through eight quotient-bit iterations, and reports completion. It optionally short-circuits a divide-by-zero. It sits between the top-level handshake and the datapath and holds no operand data itself.

## Interface
Parameters:
- `ITER`, 8: number of quotient bits. The value loaded into the datapath counter is ITER-1. Only 8 is supported by the current datapath.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a division; sampled only in IDLE
- `signbit`  in  1  datapath trial-subtraction sign (1 = negative); valid in EVAL
- `count`  in  4  datapath iteration counter
- `bzero`  in  1  divisor-is-zero flag from top level; used only with DIVCTRL_DBZ_EN
- `loadQ`, `loadM`, `initA0`, `init_counter`  out  1  operand/counter initialisation strobes
- `shift`  out  1  capture shifted A:Q pair
- `PA`  out  1  write trial difference into A (subtraction kept)
- `loadA`  out  1  write shifted A back into A (restore)
- `PQ`  out  1  write quotient bit into Q
- `dec_counter`  out  1  decrement iteration counter
- `ready`  out  1  high in IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  divide-by-zero flag; valid with `done`

## Operation
- Moore FSM with states IDLE, LOAD, SHIFT, EVAL, DONE. Outputs decode from state, plus `signbit` in EVAL.
- IDLE: `ready`=1. If `start`=1, go to LOAD. Otherwise stay.
- LOAD: assert `loadQ`, `loadM`, `initA0`, `init_counter`. Go to SHIFT.
- SHIFT: assert `shift`. Go to EVAL.
- EVAL:
  - Always assert `PQ` and `dec_counter`.
  - If `signbit`=0, assert `PA`. Otherwise assert `loadA`.
  - If `count`==0 (the value before the decrement), go to DONE. Otherwise go to SHIFT.
- DONE: `done`=1. `err` reflects the divide-by-zero path. Go to IDLE unconditionally.
- `PA` and `loadA` are never high together. No strobe is high outside the states listed above.
- `start` outside IDLE is ignored. It is not queued.
- `start` held high continuously restarts a new division after every DONE→IDLE pass.
- The controller does not reset the datapath. The datapath has its own reset.

## Timing
- Reset: state=IDLE. `ready`=1. All other outputs 0.
- `rst` mid-operation returns to IDLE on the next edge. Strobes drop immediately and the partial result is abandoned.
- Latency, with `start` sampled at edge 0:
  - LOAD occupies cycle 1.
  - SHIFT/EVAL pairs occupy cycles 2–17.
  - DONE (`done`=1) is cycle 18.
  - `ready` returns in cycle 19.
- Results on the datapath Q/R buses are valid from DONE until the next LOAD.
- Iteration count: EVAL executes exactly 8 times (count 7..0). `dec_counter` fires 8 times, and the counter ends at 4'b1111.
- `signbit` is combinational from the datapath register written in SHIFT, so it is sampled only in EVAL.

## Configuration
- `DIVCTRL_DBZ_EN` defined:
  - In IDLE, `start`=1 with `bzero`=1 goes directly to DONE with `err`=1 (done in cycle 1).
  - No datapath strobes are issued, and Q/R are left unchanged.
  - `err` is 0 on every normal completion.
- Not defined:
  - `bzero` is ignored and `err` is tied 0.
  - A zero divisor runs the full 18-cycle sequence. The datapath yields Q=0xFF.

## Test plan
- 200 / 7 → `done` in cycle 18; Q=28, R=4; exactly 8 `PQ` and 8 `dec_counter` pulses; `PA`/`loadA` never overlap.
- 255 / 1 → Q=255, R=0; `PA` asserted in all 8 EVALs. Then 5 / 9 → Q=0, R=5; `loadA` asserted in all 8 EVALs.
- `start` pulsed at cycles 4 and 10 during a running division → ignored; a single `done` at cycle 18; a `start` held through DONE begins a new LOAD at cycle 20.
- `rst` asserted in cycle 9 (mid-EVAL) → IDLE next edge, `ready`=1, all strobes 0; a following 100 / 3 gives Q=33, R=1.
- With `DIVCTRL_DBZ_EN`: 50 / 0 with `bzero`=1 → `done`=`err`=1 in cycle 1, no strobes issued. Without the macro: full sequence, `err`=0, Q=0xFF.
